// File: rtl/reset_sequencer.sv
// Central reset controller: waits for a filtered clock lock, holds all domains
// in reset for WIDTH cycles, then releases them in index order GAP cycles apart.
module reset_sequencer #(
  parameter int N_DOMAINS   = 4,
  parameter int WIDTH       = 50,
  parameter int GAP         = 16,
  parameter int LOCK_FILTER = 8
) (
  input  logic                 clk,
  input  logic                 ip_async_reset_n_i,
  input  logic                 ip_lock_i,
  input  logic                 ip_sw_reset_req_i,
  output logic                 op_sw_reset_ack_o,
  output logic [N_DOMAINS-1:0] op_reset_o,
  output logic                 op_done_o,
  output logic [2:0]           op_state_o
);

  // state     | meaning
  // WAIT_LOCK | all domains in reset, filtering ip_lock_i
  // ASSERT    | all domains in reset for WIDTH cycles
  // RELEASE   | deasserting one domain every GAP cycles, bit 0 first
  // RUN       | every domain released
  localparam logic [2:0] ST_WAIT_LOCK = 3'd0;
  localparam logic [2:0] ST_ASSERT    = 3'd1;
  localparam logic [2:0] ST_RELEASE   = 3'd2;
  localparam logic [2:0] ST_RUN       = 3'd3;

  localparam int LW = (LOCK_FILTER > 1) ? $clog2(LOCK_FILTER) : 1;
  localparam int WW = (WIDTH > 1)       ? $clog2(WIDTH)       : 1;
  localparam int GW = (GAP > 1)         ? $clog2(GAP)         : 1;
  localparam int IW = (N_DOMAINS > 1)   ? $clog2(N_DOMAINS)   : 1;

  localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_FILTER - 1);
  localparam logic [WW-1:0] WIDTH_LAST = WW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DOMAINS - 1);

  logic [2:0]           state_q, state_d;
  logic [LW-1:0]        lock_cnt_q, lock_cnt_d;
  logic [WW-1:0]        width_cnt_q, width_cnt_d;
  logic [GW-1:0]        gap_cnt_q, gap_cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic                 req_q;
  logic                 ack_q, ack_d;
  logic                 done_q, done_d;
  logic [N_DOMAINS-1:0] reset_q, reset_d;
  logic                 req_edge;
  logic                 active;

  assign req_edge = ip_sw_reset_req_i & ~req_q;
  assign active   = (state_q == ST_ASSERT) || (state_q == ST_RELEASE) || (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    lock_cnt_d  = lock_cnt_q;
    width_cnt_d = width_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    idx_d       = idx_q;
    reset_d     = reset_q;
    done_d      = done_q;
    ack_d       = 1'b0;

    if (!active) begin
      // WAIT_LOCK, and recovery from any unreachable encoding
      state_d = ST_WAIT_LOCK;
      reset_d = '1;
      done_d  = 1'b0;
      if (!ip_lock_i) begin
        lock_cnt_d = '0;
      end else if (lock_cnt_q == LOCK_LAST) begin
        state_d     = ST_ASSERT;
        width_cnt_d = '0;
        lock_cnt_d  = '0;
      end else begin
        lock_cnt_d = lock_cnt_q + 1'b1;
      end
    end else if (!ip_lock_i) begin
      state_d    = ST_WAIT_LOCK;
      lock_cnt_d = '0;
      reset_d    = '1;
      done_d     = 1'b0;
    end else if (req_edge) begin
      ack_d       = 1'b1;
      state_d     = ST_ASSERT;
      width_cnt_d = '0;
      reset_d     = '1;
      done_d      = 1'b0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          reset_d = '1;
          if (width_cnt_q == WIDTH_LAST) begin
            state_d   = ST_RELEASE;
            gap_cnt_d = '0;
            idx_d     = '0;
          end else begin
            width_cnt_d = width_cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_cnt_q == GAP_LAST) begin
            reset_d[idx_q] = 1'b0;
            gap_cnt_d      = '0;
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            gap_cnt_d = gap_cnt_q + 1'b1;
          end
        end
        default: begin
          reset_d = '0;
          done_d  = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge ip_async_reset_n_i) begin
    if (!ip_async_reset_n_i) begin
      state_q     <= ST_WAIT_LOCK;
      lock_cnt_q  <= '0;
      width_cnt_q <= '0;
      gap_cnt_q   <= '0;
      idx_q       <= '0;
      req_q       <= 1'b0;
      ack_q       <= 1'b0;
      done_q      <= 1'b0;
      reset_q     <= '1;
    end else begin
      state_q     <= state_d;
      lock_cnt_q  <= lock_cnt_d;
      width_cnt_q <= width_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      idx_q       <= idx_d;
      req_q       <= ip_sw_reset_req_i;
      ack_q       <= ack_d;
      done_q      <= done_d;
      reset_q     <= reset_d;
    end
  end

  assign op_state_o        = state_q;
  assign op_reset_o        = reset_q;
  assign op_done_o         = done_q;
  assign op_sw_reset_ack_o = ack_q;

endmodule
